// File: rtl/ahb_master_arbiter.sv
// AHB-Lite multi-master arbiter: owns address-phase grant, tracks data-phase owner,
// keeps bursts and locked sequences intact, and bounds tenure under contention.
module ahb_master_arbiter #(
    parameter int MASTER_COUNT = 2,
    parameter int PARK_MASTER  = 0,
    parameter int TENURE_MAX   = 16,
    parameter int OW           = $clog2(MASTER_COUNT)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [MASTER_COUNT-1:0]   req,
    input  logic [MASTER_COUNT-1:0]   lock,
    input  logic [2*MASTER_COUNT-1:0] trans,
    input  logic                      ready,
    output logic [MASTER_COUNT-1:0]   grant,
    output logic [OW-1:0]             addr_owner,
    output logic [OW-1:0]             data_owner,
    output logic                      data_valid,
    output logic                      locked
);

    localparam int         TW          = $clog2(TENURE_MAX + 2);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;

    logic [OW-1:0] addr_owner_q, addr_owner_d;
    logic [OW-1:0] data_owner_q, data_owner_d;
    logic          data_valid_q, data_valid_d;
    logic          locked_q, locked_d;
    logic [TW-1:0] tenure_q, tenure_d;

    logic [1:0]    owner_trans;
    logic          owner_req;
    logic          owner_lock;
    logic          others_req;
    logic          rr_found;
    logic [OW-1:0] rr_idx;
    logic          eligible;
    logic          tenure_expired;

    always_comb begin
        owner_trans = HTRANS_IDLE;
        owner_req   = 1'b0;
        owner_lock  = 1'b0;
        others_req  = 1'b0;
        grant       = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (addr_owner_q == OW'(i)) begin
                owner_trans = trans[2*i +: 2];
                owner_req   = req[i];
                owner_lock  = lock[i];
                grant[i]    = 1'b1;
            end else if (req[i]) begin
                others_req = 1'b1;
            end
        end
    end

    // Round-robin: first requester above the owner, then wrap to those below it.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = addr_owner_q;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (!rr_found && OW'(i) > addr_owner_q && req[i]) begin
                rr_found = 1'b1;
                rr_idx   = OW'(i);
            end
        end
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (!rr_found && OW'(i) < addr_owner_q && req[i]) begin
                rr_found = 1'b1;
                rr_idx   = OW'(i);
            end
        end
    end

    always_comb begin
        tenure_expired = (TENURE_MAX != 0) && (tenure_q >= TW'(TENURE_MAX));
        eligible       = ready && (owner_trans == HTRANS_IDLE) && !(owner_lock && owner_req);

        addr_owner_d = addr_owner_q;
        if (eligible) begin
            if (!owner_req) begin
                addr_owner_d = rr_found ? rr_idx : OW'(PARK_MASTER);
            end else if (tenure_expired && rr_found) begin
                addr_owner_d = rr_idx;
            end
        end

        data_owner_d = data_owner_q;
        data_valid_d = data_valid_q;
        locked_d     = locked_q;
        if (ready) begin
            data_owner_d = addr_owner_q;
            data_valid_d = (owner_trans != HTRANS_IDLE) && (owner_trans != HTRANS_BUSY);
            locked_d     = owner_lock && owner_req;
        end

        // Tenure only measures unlocked contention for the current owner.
        tenure_d = tenure_q;
        if (locked_q || owner_lock || (addr_owner_d != addr_owner_q)) begin
            tenure_d = '0;
        end else if (ready && others_req && (tenure_q < TW'(TENURE_MAX))) begin
            tenure_d = tenure_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_owner_q <= OW'(PARK_MASTER);
            data_owner_q <= OW'(PARK_MASTER);
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            tenure_q     <= '0;
        end else begin
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
            tenure_q     <= tenure_d;
        end
    end

    assign addr_owner = addr_owner_q;
    assign data_owner = data_owner_q;
    assign data_valid = data_valid_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter (2 masters, park on 0, tenure limit 4).
module tb_ahb_master_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] lock;
    logic [3:0] trans;
    logic       ready;
    logic [1:0] grant;
    logic [0:0] addr_owner;
    logic [0:0] data_owner;
    logic       data_valid;
    logic       locked;

    int n_checks = 0;
    int n_errors = 0;

    ahb_master_arbiter #(
        .MASTER_COUNT(2),
        .PARK_MASTER (0),
        .TENURE_MAX  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .trans     (trans),
        .ready     (ready),
        .grant     (grant),
        .addr_owner(addr_owner),
        .data_owner(data_owner),
        .data_valid(data_valid),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_grant"},      32'(grant),      32'h1);
        chk({tag, "_addr_owner"}, 32'(addr_owner), 32'h0);
        chk({tag, "_data_owner"}, 32'(data_owner), 32'h0);
        chk({tag, "_data_valid"}, 32'(data_valid), 32'h0);
        chk({tag, "_locked"},     32'(locked),     32'h0);
    endtask

    logic [11:0] fair_own;

    initial begin
        reset = 1'b1; req = '0; lock = '0; trans = '0; ready = 1'b0;
        step(); step();
        chk_reset_state("reset");

        // Handover from idle master0 to requesting master1
        reset = 1'b0; req = 2'b10; trans = 4'b0000; ready = 1'b1;
        step();
        chk("ho_grant", 32'(grant), 32'h2);
        chk("ho_addr_owner", 32'(addr_owner), 32'h1);
        chk("ho_data_owner_lag", 32'(data_owner), 32'h0);
        trans = 4'b1000;
        step();
        chk("ho_data_owner", 32'(data_owner), 32'h1);
        chk("ho_data_valid", 32'(data_valid), 32'h1);
        chk("ho_grant_hold", 32'(grant), 32'h2);
        trans = 4'b0000; req = 2'b00;
        step();
        chk("park_grant", 32'(grant), 32'h1);
        chk("park_data_owner", 32'(data_owner), 32'h1);
        chk("park_data_valid", 32'(data_valid), 32'h0);

        // Burst protection: 4 beats from master0 while master1 waits
        req = 2'b11;
        for (int b = 0; b < 4; b++) begin
            trans = (b == 0) ? 4'b0010 : 4'b0011;
            step();
            chk($sformatf("burst_grant_%0d", b), 32'(grant), 32'h1);
            chk($sformatf("burst_dv_%0d", b), 32'(data_valid), 32'h1);
        end
        trans = 4'b0000; req = 2'b10;
        step();
        chk("burst_end_grant", 32'(grant), 32'h2);
        chk("burst_end_data_owner", 32'(data_owner), 32'h0);
        chk("burst_end_dv", 32'(data_valid), 32'h0);

        // Return to master0, then hold a locked sequence for 30 cycles
        req = 2'b01;
        step();
        chk("ret0_grant", 32'(grant), 32'h1);
        lock = 2'b01; req = 2'b11;
        for (int c = 0; c < 30; c++) begin
            step();
            chk($sformatf("lock_grant_%0d", c), 32'(grant), 32'h1);
            chk($sformatf("lock_locked_%0d", c), 32'(locked), 32'h1);
        end
        lock = 2'b00; req = 2'b10;
        step();
        chk("unlock_grant", 32'(grant), 32'h2);
        chk("unlock_locked", 32'(locked), 32'h0);

        // Tenure fairness: both request, NONSEQ on odd edges, IDLE on even edges
        fair_own = 12'b1000_0001_1111;
        req = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            trans = (k % 2 == 1) ? 4'b1010 : 4'b0000;
            step();
            chk($sformatf("fair_owner_%0d", k), 32'(addr_owner), 32'(fair_own[k-1]));
            chk($sformatf("fair_dv_%0d", k), 32'(data_valid), (k % 2 == 1) ? 32'h1 : 32'h0);
        end

        // Wait states block a pending handover
        trans = 4'b0000; req = 2'b01; ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            step();
            chk($sformatf("wait_grant_%0d", w), 32'(grant), 32'h2);
            chk($sformatf("wait_addr_owner_%0d", w), 32'(addr_owner), 32'h1);
            chk($sformatf("wait_data_owner_%0d", w), 32'(data_owner), 32'h0);
        end
        ready = 1'b1;
        step();
        chk("wait_release_grant", 32'(grant), 32'h1);
        chk("wait_release_data_owner", 32'(data_owner), 32'h1);

        // Master1 starts a locked burst, reset lands on its SEQ beat
        req = 2'b10;
        step();
        chk("pre_rst_grant", 32'(grant), 32'h2);
        trans = 4'b1000; lock = 2'b10;
        step();
        trans = 4'b1100;
        step();
        chk("pre_rst_addr_owner", 32'(addr_owner), 32'h1);
        chk("pre_rst_data_owner", 32'(data_owner), 32'h1);
        chk("pre_rst_locked", 32'(locked), 32'h1);
        chk("pre_rst_dv", 32'(data_valid), 32'h1);
        reset = 1'b1;
        step();
        chk_reset_state("midrst");
        reset = 1'b0; req = '0; lock = '0; trans = '0;
        step();
        chk_reset_state("post_rst_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
